// File: rtl/imager_pixel_packer.sv
// imager_pixel_packer
// Collects pixels from several camera channels into fixed-width words. Each
// channel has a small word queue. A round-robin arbiter drains the queues into
// one registered valid/ready output stream. Each output word is tagged with its
// source channel, the number of valid pixels and an end-of-frame flag.
module imager_pixel_packer #(
    parameter int NUM_CAMS     = 2,
    parameter int PIX_W        = 8,
    parameter int PIX_PER_WORD = 4,
    parameter int QDEPTH       = 4,
    localparam int CH_W        = (NUM_CAMS > 1) ? $clog2(NUM_CAMS) : 1,
    localparam int CNT_W       = $clog2(PIX_PER_WORD + 1),
    localparam int OUT_W       = PIX_W * PIX_PER_WORD
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_CAMS-1:0]       chan_enable,
    input  logic [NUM_CAMS-1:0]       pix_valid,
    input  logic [NUM_CAMS*PIX_W-1:0] pix_data,
    input  logic [NUM_CAMS-1:0]       frame_done,
    output logic [NUM_CAMS-1:0]       ch_full,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [OUT_W-1:0]          out_data,
    output logic [CH_W-1:0]           out_chan,
    output logic [CNT_W-1:0]          out_count,
    output logic                      out_last,
    input  logic [NUM_CAMS-1:0]       clear_overflow,
    output logic [NUM_CAMS-1:0]       overflow_sticky
);

    // Queue entry layout: {last, count, data}
    localparam int ENT_W = OUT_W + CNT_W + 1;
    localparam int QA_W  = $clog2(QDEPTH);
    localparam int QP_W  = QA_W + 1;

    logic [NUM_CAMS-1:0]            q_empty;
    logic [NUM_CAMS-1:0]            pop;
    logic [NUM_CAMS-1:0][ENT_W-1:0] head_ent;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CAMS; gi++) begin : g_chan
            logic [CNT_W-1:0] pix_cnt_reg;
            logic [CNT_W-1:0] pix_cnt_next;
            logic [OUT_W-1:0] lane_reg;
            logic [PIX_W-1:0] pix;
            logic             pv;
            logic             fd;
            logic             push;
            logic             push_ok;
            logic             q_full;
            logic [OUT_W-1:0] push_word;
            logic [CNT_W-1:0] push_count;
            logic [QP_W-1:0]  wr_ptr_reg;
            logic [QP_W-1:0]  rd_ptr_reg;
            logic [QP_W-1:0]  occ;
            logic [QP_W-1:0]  occ_next;
            logic             full_reg;
            logic             ovf_reg;
            logic [ENT_W-1:0] mem [QDEPTH];

            assign pix = pix_data[gi*PIX_W +: PIX_W];

            // Accumulator: form the outgoing word (current pixel merged in) and the next fill level
            always_comb begin
                pv         = chan_enable[gi] & pix_valid[gi];
                fd         = chan_enable[gi] & frame_done[gi];
                push_word  = '0;
                for (int l = 0; l < PIX_PER_WORD; l++) begin
                    if (CNT_W'(l) < pix_cnt_reg)
                        push_word[l*PIX_W +: PIX_W] = lane_reg[l*PIX_W +: PIX_W];
                    else if (pv && (CNT_W'(l) == pix_cnt_reg))
                        push_word[l*PIX_W +: PIX_W] = pix;
                end
                push_count = pix_cnt_reg + CNT_W'(pv);
                push       = fd || (pv && (pix_cnt_reg == CNT_W'(PIX_PER_WORD - 1)));
                pix_cnt_next = pix_cnt_reg;
                if (!chan_enable[gi] || push)
                    pix_cnt_next = '0;
                else if (pv)
                    pix_cnt_next = pix_cnt_reg + CNT_W'(1);
            end

            // Queue occupancy; a push into a full queue is dropped even if a pop happens this cycle
            always_comb begin
                occ      = wr_ptr_reg - rd_ptr_reg;
                q_full   = (occ == QP_W'(QDEPTH));
                push_ok  = push && !q_full;
                occ_next = occ + QP_W'(push_ok) - QP_W'(pop[gi]);
            end

            assign q_empty[gi]         = (occ == '0);
            assign head_ent[gi]        = mem[rd_ptr_reg[QA_W-1:0]];
            assign ch_full[gi]         = full_reg;
            assign overflow_sticky[gi] = ovf_reg;

            // Word storage; contents need no reset because the pointers define validity
            always_ff @(posedge clk) begin
                if (push_ok)
                    mem[wr_ptr_reg[QA_W-1:0]] <= {fd, push_count, push_word};
            end

            // Per-channel state: pixel lanes, pointers, almost-full and overflow flags
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    pix_cnt_reg <= '0;
                    lane_reg    <= '0;
                    wr_ptr_reg  <= '0;
                    rd_ptr_reg  <= '0;
                    full_reg    <= 1'b0;
                    ovf_reg     <= 1'b0;
                end else begin
                    pix_cnt_reg <= pix_cnt_next;
                    for (int l = 0; l < PIX_PER_WORD; l++) begin
                        if (pv && (CNT_W'(l) == pix_cnt_reg))
                            lane_reg[l*PIX_W +: PIX_W] <= pix;
                    end
                    if (push_ok)
                        wr_ptr_reg <= wr_ptr_reg + QP_W'(1);
                    if (pop[gi])
                        rd_ptr_reg <= rd_ptr_reg + QP_W'(1);
                    // Registered from the next occupancy so the ADC sees it one cycle before the queue fills
                    full_reg <= (occ_next >= QP_W'(QDEPTH - 1));
                    if (push && q_full)
                        ovf_reg <= 1'b1;
                    else if (clear_overflow[gi])
                        ovf_reg <= 1'b0;
                end
            end
        end
    endgenerate

    logic             out_valid_reg;
    logic [OUT_W-1:0] out_data_reg;
    logic [CH_W-1:0]  out_chan_reg;
    logic [CNT_W-1:0] out_count_reg;
    logic             out_last_reg;
    logic [CH_W-1:0]  ptr_reg;
    logic             load;
    logic             grant_valid;
    logic [CH_W-1:0]  grant_idx;
    logic [ENT_W-1:0] sel_ent;
    int               arb_idx;

    // Round-robin search from ptr over non-empty queues; pops only when the output register loads
    always_comb begin
        load        = !out_valid_reg || out_ready;
        grant_valid = 1'b0;
        grant_idx   = '0;
        sel_ent     = '0;
        pop         = '0;
        arb_idx     = 0;
        for (int i = 0; i < NUM_CAMS; i++) begin
            arb_idx = int'(ptr_reg) + i;
            if (arb_idx >= NUM_CAMS)
                arb_idx = arb_idx - NUM_CAMS;
            for (int c = 0; c < NUM_CAMS; c++) begin
                if (!grant_valid && (arb_idx == c) && !q_empty[c]) begin
                    grant_valid = 1'b1;
                    grant_idx   = CH_W'(c);
                end
            end
        end
        for (int c = 0; c < NUM_CAMS; c++) begin
            if (grant_idx == CH_W'(c))
                sel_ent = head_ent[c];
            pop[c] = load && grant_valid && (grant_idx == CH_W'(c));
        end
    end

    // Output register: refills when empty or accepted, holds steady under backpressure
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_chan_reg  <= '0;
            out_count_reg <= '0;
            out_last_reg  <= 1'b0;
            ptr_reg       <= '0;
        end else if (load) begin
            out_valid_reg <= grant_valid;
            if (grant_valid) begin
                {out_last_reg, out_count_reg, out_data_reg} <= sel_ent;
                out_chan_reg <= grant_idx;
                ptr_reg <= (grant_idx == CH_W'(NUM_CAMS - 1)) ? '0 : grant_idx + CH_W'(1);
            end else begin
                out_data_reg  <= '0;
                out_chan_reg  <= '0;
                out_count_reg <= '0;
                out_last_reg  <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_chan  = out_chan_reg;
    assign out_count = out_count_reg;
    assign out_last  = out_last_reg;

endmodule
